skipjack_cbc: RTL and testbench

Cipher-block-chaining stage between the 8-to-64 FIFO adapter and `skipjack_iterative`. It XORs each 64-bit plaintext block with the chaining value (IV, then the previous ciphertext) and drives the sum into the cipher. It captures the cipher output as the new chaining value and forwards it downstream to the 64-to-8 adapter. Only one block is in flight at a time, because CBC makes each block depend on the previous ciphertext.

---
 rtl/skipjack_pkg.sv | 17 +
 rtl/skipjack_cbc_if.sv | 16 +
 rtl/skipjack_cbc.sv | 93 +++++++++
 tb/tb_skipjack_cbc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/skipjack_pkg.sv
// rtl/skipjack_pkg.sv - shared types for the Skipjack CBC chaining stage
// Purpose: block type, CBC FSM state encoding and block geometry.
// Ports: none (package).
package skipjack_pkg;

  localparam int BLOCK_BYTES = 8;

  typedef logic [BLOCK_BYTES*8-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WAIT,
    OUT
  } cbc_state_t;

endpackage

// File: rtl/skipjack_cbc_if.sv
// rtl/skipjack_cbc_if.sv - 64-bit valid/ready block stream
// Purpose: one block-wide stream link between pipeline stages.
// Ports: tdata (block), tvalid (master drives), tready (slave drives).
//   master modport: drives tdata/tvalid, observes tready.
//   slave modport : observes tdata/tvalid, drives tready.
interface skipjack_cbc_if;
  import skipjack_pkg::*;

  block_t tdata;
  logic   tvalid;
  logic   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/skipjack_cbc.sv
// rtl/skipjack_cbc.sv - CBC chaining stage around the Skipjack cipher core
// Purpose: XORs each plaintext block with the chaining value, hands it to
//   the cipher, captures the ciphertext as the next chaining value and
//   forwards it downstream. One block in flight at a time.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   iv, iv_load     initialisation vector and its load strobe (IDLE only)
//   iv_ready        high while IDLE
//   chain_en        1 = CBC, 0 = ECB pass-through (sampled at acceptance)
//   s_axis          plaintext in (slave)
//   c_m_axis        XORed block to the cipher (master)
//   c_s_axis        ciphertext from the cipher (slave)
//   m_axis          ciphertext out (master)
//   block_count     blocks delivered on m_axis, wraps
module skipjack_cbc
  import skipjack_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  block_t                 iv,
  input  logic                   iv_load,
  output logic                   iv_ready,
  input  logic                   chain_en,
  skipjack_cbc_if.slave          s_axis,
  skipjack_cbc_if.master         c_m_axis,
  skipjack_cbc_if.slave          c_s_axis,
  skipjack_cbc_if.master         m_axis,
  output logic [COUNT_WIDTH-1:0] block_count
);

  cbc_state_t             state_q;
  logic [DATA_WIDTH-1:0]  chain_q;
  logic [DATA_WIDTH-1:0]  blk_q;
  logic [DATA_WIDTH-1:0]  out_q;
  logic                   mode_q;
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chain_q <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An IV load takes the whole cycle; plaintext waits until the next.
          if (iv_load) begin
            chain_q <= iv;
          end else if (s_axis.tvalid) begin
            blk_q   <= s_axis.tdata ^ (chain_en ? chain_q : '0);
            mode_q  <= chain_en;
            state_q <= ENC;
          end
        end
        ENC: begin
          if (c_m_axis.tready) state_q <= WAIT;
        end
        WAIT: begin
          if (c_s_axis.tvalid) begin
            out_q <= c_s_axis.tdata;
            // ECB blocks must leave the chain untouched for later CBC blocks.
            if (mode_q) chain_q <= c_s_axis.tdata;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (m_axis.tready) begin
            count_q <= count_q + COUNT_WIDTH'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state; s_axis.tready also yields to iv_load.
  assign iv_ready        = (state_q == IDLE);
  assign s_axis.tready   = (state_q == IDLE) && !iv_load;
  assign c_m_axis.tvalid = (state_q == ENC);
  assign c_m_axis.tdata  = blk_q;
  assign c_s_axis.tready = (state_q == WAIT);
  assign m_axis.tvalid   = (state_q == OUT);
  assign m_axis.tdata    = out_q;
  assign block_count     = count_q;

endmodule

// File: tb/tb_skipjack_cbc.sv
// tb/tb_skipjack_cbc.sv - self-checking bench for skipjack_cbc
module tb_skipjack_cbc;
  import skipjack_pkg::*;

  localparam logic [63:0] K = 64'hFFFF0000FFFF0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] iv = '0;
  logic        iv_load = 1'b0;
  logic        iv_ready;
  logic        chain_en = 1'b0;
  logic [31:0] block_count;

  skipjack_cbc_if s_if ();
  skipjack_cbc_if c_m_if ();
  skipjack_cbc_if c_s_if ();
  skipjack_cbc_if m_if ();

  int checks = 0;
  int errors = 0;

  // Reference model state: CBC chain value and delivered-block count.
  logic [63:0] model_chain = '0;
  logic [31:0] model_count = '0;
  logic [63:0] last_in, last_out;

  always #5 clk = ~clk;

  skipjack_cbc #(.DATA_WIDTH(64), .COUNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iv         (iv),
    .iv_load    (iv_load),
    .iv_ready   (iv_ready),
    .chain_en   (chain_en),
    .s_axis     (s_if),
    .c_m_axis   (c_m_if),
    .c_s_axis   (c_s_if),
    .m_axis     (m_if),
    .block_count(block_count)
  );

  // Cipher stub: ct = pt ^ K, valid three cycles after the input handshake.
  logic [63:0] stub_data;
  logic        stub_busy;
  int          stub_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_s_if.tvalid <= 1'b0;
      c_s_if.tdata  <= '0;
      stub_busy     <= 1'b0;
      stub_cnt      <= 0;
      stub_data     <= '0;
    end else begin
      if (c_s_if.tvalid && c_s_if.tready) c_s_if.tvalid <= 1'b0;
      if (c_m_if.tvalid && c_m_if.tready) begin
        stub_data <= c_m_if.tdata ^ K;
        stub_busy <= 1'b1;
        stub_cnt  <= 1;
      end else if (stub_busy) begin
        if (stub_cnt == 2) begin
          c_s_if.tvalid <= 1'b1;
          c_s_if.tdata  <= stub_data;
          stub_busy     <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block end to end; cm_hold/m_hold stall the cipher input / output
  // side, pulse_iv fires iv_load while the block waits on the cipher.
  task automatic do_block(input logic [63:0] pt, input bit en, input int cm_hold,
                          input int m_hold, input bit pulse_iv);
    logic [63:0] exp_in, exp_out;
    int n;
    exp_in  = pt ^ (en ? model_chain : 64'h0);
    exp_out = exp_in ^ K;
    c_m_if.tready = (cm_hold == 0);
    m_if.tready   = (m_hold == 0);
    n = 0;
    @(negedge clk);
    while (!s_if.tready && n < 50) begin @(negedge clk); n++; end
    check("s_tready", 64'(s_if.tready), 64'd1);
    s_if.tdata  = pt;
    s_if.tvalid = 1'b1;
    chain_en    = en;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    chain_en    = 1'($urandom);
    check("cm_valid_next", 64'(c_m_if.tvalid), 64'd1);
    check("cm_data", c_m_if.tdata, exp_in);
    last_in = c_m_if.tdata;
    for (int i = 0; i < cm_hold; i++) begin
      @(negedge clk);
      check("cm_hold_data", c_m_if.tdata, exp_in);
      check("cm_hold_valid", 64'(c_m_if.tvalid), 64'd1);
    end
    c_m_if.tready = 1'b1;
    if (pulse_iv) begin
      n = 0;
      @(negedge clk);
      while (!c_s_if.tready && n < 50) begin @(negedge clk); n++; end
      check("wait_state", 64'(c_s_if.tready), 64'd1);
      iv      = {$urandom, $urandom};
      iv_load = 1'b1;
      check("iv_ready_busy", 64'(iv_ready), 64'd0);
      @(posedge clk);
      #1 iv_load = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!m_if.tvalid && n < 50) begin @(negedge clk); n++; end
    check("m_valid", 64'(m_if.tvalid), 64'd1);
    check("m_data", m_if.tdata, exp_out);
    last_out = m_if.tdata;
    for (int i = 0; i < m_hold; i++) begin
      @(negedge clk);
      check("m_hold_data", m_if.tdata, exp_out);
      check("m_hold_s_tready", 64'(s_if.tready), 64'd0);
      check("m_hold_count", 64'(block_count), 64'(model_count));
    end
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    if (en) model_chain = exp_out;
    model_count++;
    check("count", 64'(block_count), 64'(model_count));
    check("m_valid_drop", 64'(m_if.tvalid), 64'd0);
  endtask

  initial begin
    s_if.tvalid   = 1'b0;
    s_if.tdata    = '0;
    c_m_if.tready = 1'b1;
    m_if.tready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_iv_ready", 64'(iv_ready), 64'd1);
    check("rst_s_tready", 64'(s_if.tready), 64'd1);
    check("rst_cm_valid", 64'(c_m_if.tvalid), 64'd0);
    check("rst_cs_ready", 64'(c_s_if.tready), 64'd0);
    check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
    check("rst_count", 64'(block_count), 64'd0);
    rst_n = 1'b1;

    // IV load blocks plaintext acceptance in the same cycle
    @(negedge clk);
    iv          = 64'h0123456789ABCDEF;
    iv_load     = 1'b1;
    s_if.tdata  = 64'hDEADBEEFDEADBEEF;
    s_if.tvalid = 1'b1;
    #1 check("ivload_s_tready", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    iv_load     = 1'b0;
    s_if.tvalid = 1'b0;
    check("ivload_no_accept", 64'(c_m_if.tvalid), 64'd0);
    model_chain = 64'h0123456789ABCDEF;

    // Known-answer CBC pair
    do_block(64'h0, 1'b1, 0, 0, 1'b0);
    check("p0_cipher_in", last_in, 64'h0123456789ABCDEF);
    check("p0_out", last_out, 64'hFEDC45677654CDEF);
    do_block(64'hFEDC45677654CDEF, 1'b1, 0, 0, 1'b0);
    check("p1_cipher_in", last_in, 64'h0);
    check("p1_out", last_out, 64'hFFFF0000FFFF0000);

    // ECB twice, then CBC continues from the untouched chain
    do_block(64'h1111111111111111, 1'b0, 0, 0, 1'b0);
    check("ecb0_out", last_out, 64'hEEEE1111EEEE1111);
    do_block(64'h1111111111111111, 1'b0, 1, 0, 1'b0);
    check("ecb1_out", last_out, 64'hEEEE1111EEEE1111);
    do_block({$urandom, $urandom}, 1'b1, 3, 0, 1'b0);

    // Output backpressure for 10 cycles; count steps exactly once
    do_block({$urandom, $urandom}, 1'b1, 0, 10, 1'b0);
    @(negedge clk);
    check("count_once", 64'(block_count), 64'(model_count));

    // iv_load during WAIT is ignored; next block chains from ciphertext
    do_block({$urandom, $urandom}, 1'b1, 0, 0, 1'b1);
    do_block({$urandom, $urandom}, 1'b1, 0, 0, 1'b0);

    // Asynchronous reset while the block sits in ENC
    c_m_if.tready = 1'b0;
    @(negedge clk);
    s_if.tdata  = {$urandom, $urandom};
    s_if.tvalid = 1'b1;
    chain_en    = 1'b1;
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
    check("enc_before_rst", 64'(c_m_if.tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cm_valid", 64'(c_m_if.tvalid), 64'd0);
    check("arst_count", 64'(block_count), 64'd0);
    check("arst_s_tready", 64'(s_if.tready), 64'd1);
    check("arst_m_valid", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    c_m_if.tready = 1'b1;
    model_chain   = '0;
    model_count   = '0;
    do_block(64'hAAAAAAAAAAAAAAAA, 1'b1, 0, 0, 1'b0);
    check("post_rst_out", last_out, 64'h5555AAAA5555AAAA);
    check("post_rst_count", 64'(block_count), 64'd1);

    // Randomized traffic against the model
    for (int b = 0; b < 10; b++) begin
      do_block({$urandom, $urandom}, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
